// File: rtl/spi_sclk_engine_if.sv
// Handshake/bus bundle between the SPI control block, the SCLK engine and the
// shift register. Signal names are written from the engine's point of view.
interface spi_sclk_engine_if #(
   parameter int DIV_WIDTH = 16,
   parameter int LEN_WIDTH = 6,
   parameter int DLY_WIDTH = 4
);
   logic                 start_i;
   logic                 abort_i;
   logic                 cpol_i;
   logic                 cpha_i;
   logic [DIV_WIDTH-1:0] clk_div_i;
   logic [LEN_WIDTH-1:0] len_i;
   logic [DLY_WIDTH-1:0] setup_dly_i;
   logic [DLY_WIDTH-1:0] hold_dly_i;
   logic                 sclk_o;
   logic                 cs_o;
   logic                 busy_o;
   logic                 sample_o;
   logic                 shift_o;
   logic                 last_o;
   logic [LEN_WIDTH-1:0] bit_idx_o;
   logic                 done_o;

   // Control side: issues requests, observes the engine.
   modport master (
      output start_i, abort_i, cpol_i, cpha_i, clk_div_i, len_i, setup_dly_i, hold_dly_i,
      input  sclk_o, cs_o, busy_o, sample_o, shift_o, last_o, bit_idx_o, done_o
   );

   // Engine side.
   modport slave (
      input  start_i, abort_i, cpol_i, cpha_i, clk_div_i, len_i, setup_dly_i, hold_dly_i,
      output sclk_o, cs_o, busy_o, sample_o, shift_o, last_o, bit_idx_o, done_o
   );
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI SCLK/CS engine: generates SCLK for all four CPOL/CPHA modes, frames CS
// with programmable setup/hold delays and issues sample/shift strobes that
// line up with the visible SCLK edges. Every output is a flop.
module spi_sclk_engine #(
   parameter int DIV_WIDTH = 16,
   parameter int LEN_WIDTH = 6,
   parameter int DLY_WIDTH = 4
) (
   input logic                clk_i,
   input logic                rst_i,
   spi_sclk_engine_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_RUN   = 3'd2,
      S_HOLD  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e               state_q, state_d;

   // Frame configuration captured at start so the host may change inputs.
   logic                 cpol_q, cpol_d;
   logic                 cpha_q, cpha_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [DLY_WIDTH-1:0] hold_q, hold_d;

   // Sequencing counters.
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;     // half-period down counter
   logic [DLY_WIDTH-1:0] dly_q, dly_d;     // remaining setup/hold half-periods
   logic [LEN_WIDTH-1:0] bit_q, bit_d;     // bit currently on the wire
   logic                 phase_q, phase_d; // 0: next edge leading, 1: trailing
   logic                 fin_q, fin_d;     // final edge has been issued

   // Registered outputs.
   logic                 sclk_q, sclk_d;
   logic                 cs_q, cs_d;
   logic                 busy_q, busy_d;
   logic                 sample_q, sample_d;
   logic                 shift_q, shift_d;
   logic                 last_q, last_d;
   logic [LEN_WIDTH-1:0] bit_idx_q, bit_idx_d;
   logic                 done_q, done_d;

   logic tick;
   logic abort_act;
   logic run_edge;

   assign tick      = (cnt_q == '0);
   assign abort_act = bus.abort_i && (state_q != S_IDLE);
   // An SCLK edge is launched on a RUN tick, unless the frame is finishing
   // or being abandoned (abort wins over a coincident tick).
   assign run_edge  = (state_q == S_RUN) && !fin_q && tick && !abort_act;

   // State and sequencing registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cpol_q  <= 1'b0;
         cpha_q  <= 1'b0;
         div_q   <= '0;
         len_q   <= '0;
         hold_q  <= '0;
         cnt_q   <= '0;
         dly_q   <= '0;
         bit_q   <= '0;
         phase_q <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cpol_q  <= cpol_d;
         cpha_q  <= cpha_d;
         div_q   <= div_d;
         len_q   <= len_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
         bit_q   <= bit_d;
         phase_q <= phase_d;
         fin_q   <= fin_d;
      end
   end

   // Next-state and counter sequencing.
   always_comb begin
      state_d = state_q;
      cpol_d  = cpol_q;
      cpha_d  = cpha_q;
      div_d   = div_q;
      len_d   = len_q;
      hold_d  = hold_q;
      cnt_d   = tick ? div_q : cnt_q - DIV_WIDTH'(1);
      dly_d   = dly_q;
      bit_d   = bit_q;
      phase_d = phase_q;
      fin_d   = fin_q;

      case (state_q)
         S_IDLE: begin
            cnt_d   = cnt_q;
            bit_d   = '0;
            phase_d = 1'b0;
            fin_d   = 1'b0;
            if (bus.start_i) begin
               cpol_d  = bus.cpol_i;
               cpha_d  = bus.cpha_i;
               div_d   = bus.clk_div_i;
               len_d   = bus.len_i;
               hold_d  = bus.hold_dly_i;
               cnt_d   = bus.clk_div_i;
               dly_d   = bus.setup_dly_i;
               state_d = (bus.setup_dly_i != '0) ? S_SETUP : S_RUN;
            end
         end
         S_SETUP: begin
            // Counter reloads on the expiring tick, which also serves as the
            // load on entry to RUN.
            if (tick) begin
               if (dly_q == DLY_WIDTH'(1)) state_d = S_RUN;
               else                        dly_d   = dly_q - DLY_WIDTH'(1);
            end
         end
         S_RUN: begin
            if (fin_q) begin
               // One settling cycle after the last edge, then hold or finish.
               fin_d   = 1'b0;
               cnt_d   = div_q;
               dly_d   = hold_q;
               state_d = (hold_q != '0) ? S_HOLD : S_DONE;
            end else if (tick) begin
               phase_d = ~phase_q;
               if (phase_q) begin
                  if (bit_q == len_q) fin_d = 1'b1;
                  else                bit_d = bit_q + LEN_WIDTH'(1);
               end
            end
         end
         S_HOLD: begin
            if (tick) begin
               if (dly_q == DLY_WIDTH'(1)) state_d = S_DONE;
               else                        dly_d   = dly_q - DLY_WIDTH'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_act) begin
         state_d = S_IDLE;
         fin_d   = 1'b0;
         bit_d   = '0;
         phase_d = 1'b0;
      end
   end

   // Output next-values, derived from the current state and the next state.
   always_comb begin
      sclk_d   = sclk_q;
      sample_d = 1'b0;
      shift_d  = 1'b0;
      last_d   = 1'b0;
      done_d   = (state_d == S_DONE);
      cs_d     = (state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_HOLD);
      busy_d   = cs_d;

      case (state_q)
         S_IDLE: sclk_d = bus.cpol_i;
         S_RUN: begin
            if (run_edge) begin
               sclk_d = ~sclk_q;
               if (!phase_q) begin
                  sample_d = !cpha_q;
                  shift_d  = cpha_q;
               end else begin
                  sample_d = cpha_q;
                  // No shift after the final bit in mode CPHA=0.
                  shift_d  = !cpha_q && (bit_q != len_q);
               end
               last_d = sample_d && (bit_q == len_q);
            end
         end
         default: sclk_d = cpol_q;
      endcase

      if (abort_act) begin
         sclk_d   = cpol_q;
         sample_d = 1'b0;
         shift_d  = 1'b0;
         last_d   = 1'b0;
      end

      // Bit index advances the cycle after each sample, except the last one.
      if (state_d == S_IDLE)        bit_idx_d = '0;
      else if (sample_q && !last_q) bit_idx_d = bit_idx_q + LEN_WIDTH'(1);
      else                          bit_idx_d = bit_idx_q;
   end

   // Output registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sclk_q    <= 1'b0;
         cs_q      <= 1'b0;
         busy_q    <= 1'b0;
         sample_q  <= 1'b0;
         shift_q   <= 1'b0;
         last_q    <= 1'b0;
         bit_idx_q <= '0;
         done_q    <= 1'b0;
      end else begin
         sclk_q    <= sclk_d;
         cs_q      <= cs_d;
         busy_q    <= busy_d;
         sample_q  <= sample_d;
         shift_q   <= shift_d;
         last_q    <= last_d;
         bit_idx_q <= bit_idx_d;
         done_q    <= done_d;
      end
   end

   assign bus.sclk_o    = sclk_q;
   assign bus.cs_o      = cs_q;
   assign bus.busy_o    = busy_q;
   assign bus.sample_o  = sample_q;
   assign bus.shift_o   = shift_q;
   assign bus.last_o    = last_q;
   assign bus.bit_idx_o = bit_idx_q;
   assign bus.done_o    = done_q;

endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine. Cycle k counts clk_i edges after the
// edge that accepted start_i (start held during k=0). Outputs are sampled 1ns
// after each rising edge; inputs are changed right after sampling.
module tb_spi_sclk_engine;

   logic clk_i = 1'b0;
   logic rst_i;
   int   checks = 0;
   int   errors = 0;

   always #5 clk_i = ~clk_i;

   spi_sclk_engine_if bus ();

   spi_sclk_engine dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare every output against expected values for one cycle.
   task automatic chk_all(input string tag, input int k, input int sclk, input int cs,
                          input int sample, input int shift, input int last,
                          input int done, input int bidx);
      string t;
      t = $sformatf("%s k=%0d", tag, k);
      chk({t, " sclk"},    int'(bus.sclk_o),    sclk);
      chk({t, " cs"},      int'(bus.cs_o),      cs);
      chk({t, " busy"},    int'(bus.busy_o),    cs);
      chk({t, " sample"},  int'(bus.sample_o),  sample);
      chk({t, " shift"},   int'(bus.shift_o),   shift);
      chk({t, " last"},    int'(bus.last_o),    last);
      chk({t, " done"},    int'(bus.done_o),    done);
      chk({t, " bit_idx"}, int'(bus.bit_idx_o), bidx);
   endtask

   task automatic cfg(input logic cpol, input logic cpha, input int div, input int len,
                      input int setup, input int hold);
      bus.cpol_i      = cpol;
      bus.cpha_i      = cpha;
      bus.clk_div_i   = 16'(div);
      bus.len_i       = 6'(len);
      bus.setup_dly_i = 4'(setup);
      bus.hold_dly_i  = 4'(hold);
   endtask

   initial begin
      int e_sclk, e_smp, e_sh, e_bidx, idx;
      logic edge_k;

      rst_i = 1'b1;
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      cfg(1'b1, 1'b0, 0, 7, 0, 0);
      cyc();
      cyc();
      // Reset state: sclk forced low even though cpol_i is 1.
      chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      rst_i = 1'b0;
      cfg(1'b0, 1'b0, 0, 7, 0, 0);
      cyc();
      cyc();

      // ---- Mode 0, div=0, len=7, no delays; start re-asserted mid-frame,
      // during DONE (both ignored) and right after DONE (accepted).
      bus.start_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         e_sclk = (k >= 2 && k <= 17 && k % 2 == 0) ? 1 : 0;
         e_smp  = (k >= 2 && k <= 16 && k % 2 == 0) ? 1 : 0;
         e_sh   = (k >= 3 && k <= 15 && k % 2 == 1) ? 1 : 0;
         e_bidx = (k >= 2 && k <= 18) ? (((k - 1) / 2 > 7) ? 7 : (k - 1) / 2) : 0;
         chk_all("m0", k, e_sclk, (k <= 17 || k == 20) ? 1 : 0, e_smp, e_sh,
                 (k == 16) ? 1 : 0, (k == 18) ? 1 : 0, e_bidx);
         bus.start_i = (k == 5 || k == 18 || k == 19) ? 1'b1 : 1'b0;
         bus.abort_i = (k == 20) ? 1'b1 : 1'b0;
         cyc();
      end
      bus.abort_i = 1'b0;
      chk_all("m0 abort", 21, 0, 0, 0, 0, 0, 0, 0);

      // ---- Mode 3, div=3, len=3, setup=2, hold=1. Inputs scrambled after
      // start to show the configuration is latched.
      cfg(1'b1, 1'b1, 3, 3, 2, 1);
      cyc();
      chk("m3 idle sclk", int'(bus.sclk_o), 1);
      bus.start_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      cfg(1'b0, 1'b0, 0, 0, 0, 0);
      for (int k = 1; k <= 47; k++) begin
         idx    = (k - 13) / 4;
         edge_k = (k >= 13 && k <= 41 && (k - 13) % 4 == 0);
         if (k < 13 || k > 41) e_sclk = 1;
         else                  e_sclk = (idx % 2 == 0) ? 0 : 1;
         e_sh   = (edge_k && idx % 2 == 0) ? 1 : 0;
         e_smp  = (edge_k && idx % 2 == 1) ? 1 : 0;
         e_bidx = (k <= 17) ? 0 : (k <= 25) ? 1 : (k <= 33) ? 2 : (k <= 46) ? 3 : 0;
         chk_all("m3", k, e_sclk, (k <= 45) ? 1 : 0, e_smp, e_sh,
                 (k == 41) ? 1 : 0, (k == 46) ? 1 : 0, e_bidx);
         cyc();
      end
      cyc();

      // ---- Mode 1, div=1, len=3: abort on the 5th edge, then restart at once.
      cfg(1'b0, 1'b1, 1, 3, 0, 0);
      bus.start_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         idx    = (k - 3) / 2;
         edge_k = (k >= 3 && (k - 3) % 2 == 0);
         e_sclk = (k >= 3 && idx % 2 == 0) ? 1 : 0;
         e_sh   = (edge_k && idx % 2 == 0) ? 1 : 0;
         e_smp  = (edge_k && idx % 2 == 1) ? 1 : 0;
         e_bidx = (k <= 5) ? 0 : (k <= 9) ? 1 : 2;
         chk_all("m1", k, e_sclk, 1, e_smp, e_sh, 0, 0, e_bidx);
         cyc();
         if (k == 10) bus.abort_i = 1'b1;
      end
      bus.abort_i = 1'b0;
      chk_all("m1 aborted", 12, 0, 0, 0, 0, 0, 0, 0);
      bus.start_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      chk_all("m1 restart", 13, 0, 1, 0, 0, 0, 0, 0);
      cyc();
      chk_all("m1 restart", 14, 0, 1, 0, 0, 0, 0, 0);
      bus.abort_i = 1'b1;
      cyc();
      chk_all("m1 abort2", 15, 0, 0, 0, 0, 0, 0, 0);
      // Abort while idle is harmless.
      cyc();
      bus.abort_i = 1'b0;
      chk_all("idle abort", 16, 0, 0, 0, 0, 0, 0, 0);

      // ---- len=0, div=1, mode 0; start and abort together start the frame.
      cfg(1'b0, 1'b0, 1, 0, 0, 0);
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk_all("len0", k, (k == 3 || k == 4) ? 1 : 0, (k <= 5) ? 1 : 0,
                 (k == 3) ? 1 : 0, 0, (k == 3) ? 1 : 0, (k == 6) ? 1 : 0, 0);
         cyc();
      end

      // ---- Reset mid-RUN with cpol=1.
      cfg(1'b1, 1'b0, 0, 7, 0, 0);
      cyc();
      bus.start_i = 1'b1;
      cyc();
      bus.start_i = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         e_sclk = (k >= 2 && k % 2 == 0) ? 0 : 1;
         chk("rst pre sclk", int'(bus.sclk_o), e_sclk);
         if (k < 6) cyc();
      end
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      chk_all("rst mid", 7, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      chk_all("rst idle", 8, 1, 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_sclk_engine.md
Name: spi_sclk_engine

Overview:
- Parametrised successor to the SPI clock generator. Adds full CPOL/CPHA mode support, programmable frame length, and chip-select setup/hold delays.
- Implements a start/done handshake and an abort path.
- Sits between the SPI control/register block and the shift register: drives SCLK and CS, and issues single-cycle sample/shift strobes to the datapath.

Parameters:
- DIV_WIDTH, 16, width of the clock divider; SCLK half-period = clk_div_i+1 clk_i cycles.
- LEN_WIDTH, 6, width of frame-length field; bits per frame = len_i+1 (1..2^LEN_WIDTH).
- DLY_WIDTH, 4, width of CS setup/hold delay fields, counted in SCLK half-periods.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request; accepted only in IDLE.
- abort_i  in  1  abandon current frame.
- cpol_i  in  1  SCLK idle level.
- cpha_i  in  1  0: sample leading edge / shift trailing edge; 1: shift leading edge / sample trailing edge.
- clk_div_i  in  DIV_WIDTH  half-period minus one.
- len_i  in  LEN_WIDTH  bits per frame minus one.
- setup_dly_i  in  DLY_WIDTH  CS-to-first-edge delay, in half-periods.
- hold_dly_i  in  DLY_WIDTH  last-edge-to-CS-release delay, in half-periods.
- sclk_o  out  1  SPI serial clock.
- cs_o  out  1  chip-select active (high = asserted).
- busy_o  out  1  frame in progress.
- sample_o  out  1  one-cycle strobe: capture MISO.
- shift_o  out  1  one-cycle strobe: drive next MOSI bit.
- last_o  out  1  one-cycle strobe coincident with the final sample_o.
- bit_idx_o  out  LEN_WIDTH  index of the current bit (0 = first).
- done_o  out  1  one-cycle pulse at end of HOLD.

Behaviour:
- Reset (rst_i high at a clk_i edge): state IDLE.
  - sclk_o=0; cs_o, busy_o, sample_o, shift_o, last_o, done_o = 0; bit_idx_o=0.
  - Counters cleared. rst_i has priority over every other input.
- All outputs are registered.
- IDLE:
  - sclk_o <= cpol_i each cycle (one-cycle lag); strobes 0.
  - start_i accepted at cycle T: latches cpol, cpha, div, len, setup_dly, hold_dly. Inputs may change afterwards without effect.
  - At T+1: busy_o=1, cs_o=1. Next state is SETUP if setup_dly>0, else RUN.
- Half-period counter:
  - Loads div on entry to SETUP, RUN or HOLD, and after each expiry.
  - Decrements each cycle; "tick" when it equals 0.
- SETUP: sclk_o held at cpol. After setup_dly ticks -> RUN.
- RUN:
  - Each tick toggles sclk_o, visible the next cycle, in the same cycle as the associated strobe.
  - Edges alternate leading/trailing, starting with leading; 2*(len+1) edges total.
  - First edge is visible at T+1+(setup_dly+1)*(div+1).
  - cpha=0: sample_o on every leading edge; shift_o on every trailing edge except the final one.
  - cpha=1: shift_o on every leading edge; sample_o on every trailing edge.
  - bit_idx_o increments in the cycle after each bit's sample_o, with no increment after the final bit.
  - last_o is asserted with the sample_o of bit len.
  - After the final (trailing) edge, sclk_o = cpol. Next state is HOLD if hold_dly>0, else DONE.
- HOLD: sclk_o=cpol, cs_o=1; after hold_dly ticks -> DONE.
- DONE (one cycle):
  - done_o=1, cs_o=0, busy_o=0.
  - Next state is IDLE; bit_idx_o is cleared on leaving DONE.
  - start_i is ignored during DONE and is accepted again from the following cycle.
- abort_i in any non-IDLE state:
  - Next cycle: IDLE, sclk_o=cpol, cs_o=0, busy_o=0; all strobes forced 0.
  - No done_o pulse.
  - Abort has priority over a simultaneous tick.
- start_i while not IDLE: ignored; no queuing.
- abort_i in IDLE: no effect.
- A simultaneous start_i and abort_i in IDLE starts the frame.
- div=0 (divide-by-2): a tick occurs every cycle, so SCLK toggles every clk_i cycle. No special-case logic; strobes follow the same rules.
- len=0: a one-bit frame with two edges.
  - cpha=0: one sample_o with last_o, and no shift_o.
  - cpha=1: one shift_o, then sample_o with last_o.
- Counter widths are exact; no overflow paths, since maximum counts fit the declared widths.

Test Plan:
- Mode 0, div=0, len=7, setup=0, hold=0, start at T:
  - cs_o rises at T+1; 16 sclk_o edges at T+2..T+17.
  - 8 sample_o on rising edges, 7 shift_o on falling edges; last_o at T+16.
  - done_o at T+18; busy_o low at T+18.
- Mode 3 (cpol=1, cpha=1), div=3, len=3, setup=2, hold=1:
  - sclk idles high; first edge (falling) at T+13, with shift_o.
  - 4 sample_o on rising edges, each 8 cycles apart; done_o 4 cycles after the last edge plus 1.
- Abort at the 5th edge of a mode-1 frame:
  - next cycle cs_o=0, busy_o=0, sclk_o=0; no done_o; no further strobes.
  - A new start_i is accepted immediately.
- start_i re-asserted mid-frame and during DONE: ignored, frame timing unchanged. start_i one cycle after DONE: accepted.
- len=0, div=1, cpha=0: exactly one sample_o (with last_o), zero shift_o; sclk period 4 cycles.
- rst_i asserted mid-RUN with cpol=1: next cycle all outputs at reset values (sclk_o=0). Following IDLE cycle: sclk_o returns to 1.
